// File: rtl/cnn_pkg.sv
// Shared encodings for the CNN datapath: multiplier precision modes (identical to
// gated_fu) and the accumulator FSM states.
package cnn_pkg;

    typedef enum logic [1:0] {
        MODE_8X8 = 2'b00,
        MODE_4X4 = 2'b01,
        MODE_2X2 = 2'b10,
        MODE_INV = 2'b11
    } mode_e;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam int NUM_LANES = 4;

endpackage

// File: rtl/fu_acc_lane.sv
// One accumulator lane: clearable adder register with a sticky carry-out flag.
// Build macro ACC_SATURATE_EN clamps an overflowing lane to all-ones instead of wrapping.
module fu_acc_lane #(
    parameter int LANE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_en,
    input  logic              clr,
    input  logic [LANE_W-1:0] addend,
    output logic [LANE_W-1:0] acc,
    output logic              ovf
);

    logic [LANE_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, addend};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            if (sum[LANE_W]) begin
                ovf <= 1'b1;
            end
`ifdef ACC_SATURATE_EN
            // A lane already at all-ones overflows on any non-zero addend, so it stays clamped.
            acc <= sum[LANE_W] ? '1 : sum[LANE_W-1:0];
`else
            acc <= sum[LANE_W-1:0];
`endif
        end
    end

endmodule

// File: rtl/fu_accumulator.sv
// Tile accumulator behind gated_fu: unpacks product words into 4 lanes and hands each
// tile's sums out over valid/ready. Build macro ACC_SATURATE_EN selects clamping lanes.
module fu_accumulator
    import cnn_pkg::*;
#(
    parameter int LANE_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_p,
    input  logic [1:0]                    in_mode,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*LANE_W-1:0]   out_acc,
    output logic [1:0]                    out_mode,
    output logic [CNT_W-1:0]              out_count,
    output logic [NUM_LANES-1:0]          out_ovf
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the sender holds its payload stable while valid is high and ready is low.
    state_e           state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] count;
    mode_e            eff_mode;
    logic             accept;
    logic             drain_done;
    logic [LANE_W-1:0] addend [NUM_LANES];

    assign accept     = in_valid && in_ready;
    assign drain_done = out_valid && out_ready;
    // The first beat of a tile steers itself with in_mode; later beats use the latched copy.
    assign eff_mode   = mode_e'((count == '0) ? in_mode : mode_q);
    assign out_mode   = mode_q;
    assign out_count  = count;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            addend[i] = '0;
        end
        case (eff_mode)
            MODE_8X8: addend[0] = LANE_W'(in_p);
            MODE_4X4: begin
                addend[0] = LANE_W'(in_p[7:0]);
                addend[1] = LANE_W'(in_p[15:8]);
            end
            MODE_2X2: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    addend[i] = LANE_W'(in_p[4*i +: 4]);
                end
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fu_acc_lane #(.LANE_W(LANE_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .add_en (accept),
            .clr    (drain_done),
            .addend (addend[i]),
            .acc    (out_acc[i*LANE_W +: LANE_W]),
            .ovf    (out_ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
            mode_q    <= 2'b00;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == '0) begin
                            mode_q <= in_mode;
                        end
                        if (in_last) begin
                            state     <= ST_DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        state     <= ST_ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= ST_ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_accumulator.sv
// Directed bench for fu_accumulator: table of tiles plus hand sequences for
// backpressure, overflow (16-bit lanes) and reset mid-tile / mid-drain.
module tb_fu_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready16;
    logic [15:0] in_p;
    logic [1:0]  in_mode;
    logic        in_last;
    logic        out_valid, out_valid16;
    logic        out_ready;
    logic [95:0] out_acc;
    logic [63:0] out_acc16;
    logic [1:0]  out_mode, out_mode16;
    logic [15:0] out_count, out_count16;
    logic [3:0]  out_ovf, out_ovf16;

    int n_cmp = 0;
    int n_err = 0;
    logic [95:0] exp_q[$];

    typedef struct packed {
        logic [2:0]       nb;
        logic [3:0][15:0] p;
        logic [3:0][1:0]  m;
        logic [95:0]      acc;
        logic [1:0]       mode;
        logic [15:0]      cnt;
        logic [3:0]       ovf;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    fu_accumulator u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
        .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_mode(out_mode), .out_count(out_count), .out_ovf(out_ovf)
    );

    fu_accumulator #(.LANE_W(16), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_p(in_p),
        .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
        .out_acc(out_acc16), .out_mode(out_mode16), .out_count(out_count16), .out_ovf(out_ovf16)
    );

    function automatic logic [95:0] pack(input int l0, input int l1, input int l2, input int l3);
        logic [23:0] a0, a1, a2, a3;
        a0 = l0[23:0]; a1 = l1[23:0]; a2 = l2[23:0]; a3 = l3[23:0];
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input int nb, input logic [3:0][15:0] p, input logic [3:0][1:0] m,
                                input logic [95:0] acc, input logic [1:0] mode,
                                input int cnt, input logic [3:0] ovf);
        vec_t v;
        v.nb = nb[2:0]; v.p = p; v.m = m; v.acc = acc; v.mode = mode;
        v.cnt = cnt[15:0]; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beats(input vec_t v);
        for (int b = 0; b < int'(v.nb); b++) begin
            @(negedge clk);
            check("in_ready_accum", 96'(in_ready), 96'd1);
            in_valid = 1'b1;
            in_p     = v.p[b];
            in_mode  = v.m[b];
            in_last  = (b == int'(v.nb) - 1);
        end
        exp_q.push_back(v.acc);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input vec_t v);
        logic [95:0] e;
        e = exp_q.pop_front();
        check("latency_out_valid", 96'(out_valid), 96'd1);
        check("drain_in_ready", 96'(in_ready), 96'd0);
        check("out_acc", out_acc, e);
        check("out_count", 96'(out_count), 96'(v.cnt));
        check("out_mode", 96'(out_mode), 96'(v.mode));
        check("out_ovf", 96'(out_ovf), 96'(v.ovf));
    endtask

    task automatic release_tile();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("cleared_out_valid", 96'(out_valid), 96'd0);
        check("cleared_in_ready", 96'(in_ready), 96'd1);
        check("cleared_count", 96'(out_count), 96'd0);
        check("cleared_acc", out_acc, 96'd0);
        check("cleared_ovf", 96'(out_ovf), 96'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 96'(out_valid), 96'd0);
        check({tag, "_in_ready"}, 96'(in_ready), 96'd1);
        check({tag, "_out_count"}, 96'(out_count), 96'd0);
        check({tag, "_out_ovf"}, 96'(out_ovf), 96'd0);
        check({tag, "_out_mode"}, 96'(out_mode), 96'd0);
        check({tag, "_out_acc"}, out_acc, 96'd0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; in_p = '0; in_mode = 2'b00; in_last = 1'b0; out_ready = 1'b0;

        // Table: 8x8, 4x4, 2x2 with ignored mode change, invalid mode, single beat, 24-bit no-ovf.
        vecs[0] = mk(3, {16'd0, 16'd300, 16'd200, 16'd100}, {2'b00, 2'b00, 2'b00, 2'b00},
                     pack(600, 0, 0, 0), 2'b00, 3, 4'b0000);
        vecs[1] = mk(2, {16'd0, 16'd0, 16'h0504, 16'h0302}, {2'b00, 2'b00, 2'b01, 2'b01},
                     pack(6, 8, 0, 0), 2'b01, 2, 4'b0000);
        vecs[2] = mk(2, {16'd0, 16'd0, 16'h4321, 16'h4321}, {2'b00, 2'b00, 2'b00, 2'b10},
                     pack(2, 4, 6, 8), 2'b10, 2, 4'b0000);
        vecs[3] = mk(3, {16'd0, 16'hFFFF, 16'h1234, 16'hFFFF}, {2'b00, 2'b00, 2'b00, 2'b11},
                     pack(0, 0, 0, 0), 2'b11, 3, 4'b0000);
        vecs[4] = mk(1, {16'd0, 16'd0, 16'd0, 16'd7}, {2'b00, 2'b00, 2'b00, 2'b00},
                     pack(7, 0, 0, 0), 2'b00, 1, 4'b0000);
        vecs[5] = mk(4, {16'h00F1, 16'hFFFF, 16'h8001, 16'hA5A5}, {2'b01, 2'b10, 2'b00, 2'b01},
                     pack(16'hA5 + 16'h01 + 16'hFF + 16'hF1, 16'hA5 + 16'h80 + 16'hFF + 16'h00, 0, 0),
                     2'b01, 4, 4'b0000);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 6; i++) begin
            send_beats(vecs[i]);
            check_result(vecs[i]);
            release_tile();
        end

        // Backpressure: result held for 5 cycles while beats are offered and refused.
        v = mk(1, {16'd0, 16'd0, 16'd0, 16'd5}, {2'b00, 2'b00, 2'b00, 2'b00},
               pack(5, 0, 0, 0), 2'b00, 1, 4'b0000);
        send_beats(v);
        check_result(v);
        in_valid = 1'b1; in_p = 16'h0100; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 96'(out_valid), 96'd1);
            check("bp_in_ready", 96'(in_ready), 96'd0);
            check("bp_out_acc", out_acc, pack(5, 0, 0, 0));
            check("bp_out_count", 96'(out_count), 96'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        release_tile();
        v = mk(1, {16'd0, 16'd0, 16'd0, 16'd3}, {2'b00, 2'b00, 2'b00, 2'b00},
               pack(3, 0, 0, 0), 2'b00, 1, 4'b0000);
        send_beats(v);
        check_result(v);
        release_tile();

        // Overflow: 16-bit lanes carry out, 24-bit lanes do not.
        v = mk(2, {16'd0, 16'd0, 16'h0002, 16'hFFFF}, {2'b00, 2'b00, 2'b00, 2'b00},
               pack(32'h10001, 0, 0, 0), 2'b00, 2, 4'b0000);
        send_beats(v);
        check_result(v);
        check("ovf16_out_valid", 96'(out_valid16), 96'd1);
`ifdef ACC_SATURATE_EN
        check("ovf16_lane0", 96'(out_acc16), 96'h0000_0000_0000_FFFF);
`else
        check("ovf16_lane0", 96'(out_acc16), 96'h0000_0000_0000_0001);
`endif
        check("ovf16_flags", 96'(out_ovf16), 96'b0001);
        check("ovf16_count", 96'(out_count16), 96'd2);
        release_tile();
        check("ovf16_cleared", 96'(out_ovf16), 96'd0);

        // Reset after 2 beats of an open tile.
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            in_valid = 1'b1; in_p = 16'd50; in_mode = 2'b01; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("midtile_count", 96'(out_count), 96'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_midtile");
        v = mk(1, {16'd0, 16'd0, 16'd0, 16'd7}, {2'b00, 2'b00, 2'b00, 2'b00},
               pack(7, 0, 0, 0), 2'b00, 1, 4'b0000);
        send_beats(v);
        check_result(v);

        // Reset while the result is being held.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
